// File: rtl/pool_area_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool_area_pkg
// Brief    : Shared types and constants for the pool-area calculator.
// Revision : 1.0 - initial release
// ============================================================================
package pool_area_pkg;

    typedef enum logic [1:0] {
        MODE_TOTAL  = 2'b00,
        MODE_SQUARE = 2'b01,
        MODE_CIRCLE = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // pi/4 ~= CIRC_NUM / 2^CIRC_SHIFT
    localparam int CIRC_NUM   = 201;
    localparam int CIRC_SHIFT = 8;
    localparam int CIRC_RND   = 128;

endpackage
`default_nettype wire

// File: rtl/pool_area_calc_mul.sv
`default_nettype none
// ============================================================================
// Module   : pool_seq_mul
// Brief    : W-bit unsigned shift-add multiplier, one partial product per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pool_seq_mul #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod,
    output logic           done
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] r_mcand;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_mcand  <= {{W{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= CW'(W);
        end else if (r_cnt != '0) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CW'(1);
        end
    end

    assign prod = r_acc;
    // High during the cycle whose closing edge performs the final step.
    assign done = (r_cnt == CW'(1));

endmodule
`default_nettype wire

// File: rtl/pool_area_calc.sv
`default_nettype none
// ============================================================================
// Module   : pool_area_calc
// Brief    : Handshaked square/circle/total area engine with ID passthrough.
//            POOL_AREA_ROUND_EN selects round-half-up for the circle term.
// Revision : 1.0 - initial release
// ============================================================================
module pool_area_calc
    import pool_area_pkg::*;
#(
    parameter int W    = 8,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_width,
    input  logic [1:0]      in_mode,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*W:0]    out_area,
    output logic [ID_W-1:0] out_id
);
    localparam int PW = 2 * W + CIRC_SHIFT;

    state_t            r_state;
    mode_t             r_mode;
    logic [ID_W-1:0]   r_id;
    logic [2*W:0]      r_out_area;
    logic [ID_W-1:0]   r_out_id;
    logic              r_out_valid;

    logic              w_accept;
    logic              w_mul_done;
    logic [2*W-1:0]    w_sq;
    logic [PW-1:0]     w_wide;
    logic [PW-1:0]     w_scaled;
    logic [2*W-1:0]    w_circ;
    logic [2*W:0]      w_total;
    logic [2*W:0]      w_sel;
    logic              w_unused_frac;

    assign in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    pool_seq_mul #(
        .W (W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_accept),
        .a     (in_width),
        .b     (in_width),
        .prod  (w_sq),
        .done  (w_mul_done)
    );

    // 201 = 128 + 64 + 8 + 1
    assign w_wide = {{CIRC_SHIFT{1'b0}}, w_sq};
`ifdef POOL_AREA_ROUND_EN
    assign w_scaled = (w_wide << 7) + (w_wide << 6) + (w_wide << 3) + w_wide + PW'(CIRC_RND);
`else
    assign w_scaled = (w_wide << 7) + (w_wide << 6) + (w_wide << 3) + w_wide;
`endif
    assign w_circ        = w_scaled[PW-1:CIRC_SHIFT];
    assign w_unused_frac = ^w_scaled[CIRC_SHIFT-1:0];
    assign w_total       = {1'b0, w_sq} + {1'b0, w_circ};

    always_comb begin
        w_sel = w_total;
        case (r_mode)
            MODE_SQUARE: w_sel = {1'b0, w_sq};
            MODE_CIRCLE: w_sel = {1'b0, w_circ};
            default:     w_sel = w_total;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= MODE_TOTAL;
            r_id        <= '0;
            r_out_area  <= '0;
            r_out_id    <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mode  <= mode_t'(in_mode);
                        r_id    <= in_id;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (w_mul_done) begin
                        r_state <= S_SCALE;
                    end
                end
                S_SCALE: begin
                    r_out_area  <= w_sel;
                    r_out_id    <= r_id;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_area  = r_out_area;
    assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_pool_area_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_area_calc
// Brief    : Directed self-checking bench for pool_area_calc (W=8, ID_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_area_calc;
    localparam int W    = 8;
    localparam int ID_W = 2;
`ifdef POOL_AREA_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_width = '0;
    logic [1:0]      in_mode = '0;
    logic [ID_W-1:0] in_id = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W:0]    out_area;
    logic [ID_W-1:0] out_id;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    pool_area_calc #(.W(W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_width  (in_width),
        .in_mode   (in_mode),
        .in_id     (in_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_area  (out_area),
        .out_id    (out_id)
    );

    typedef struct {
        logic [W-1:0]    w;
        logic [1:0]      mode;
        logic [ID_W-1:0] id;
        int              exp_trunc;
        int              exp_rnd;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one request; optionally consume the result immediately.
    task automatic do_req(input logic [W-1:0] w, input logic [1:0] m, input logic [ID_W-1:0] id,
                          input bit consume, output int area, output int oid, output int lat);
        int t;
        @(negedge clk);
        in_valid = 1'b1; in_width = w; in_mode = m; in_id = id;
        t = 0;
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_width = W'($urandom); in_mode = 2'($urandom); in_id = ID_W'($urandom);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!out_valid && lat < 40);
        area = int'(out_area);
        oid  = int'(out_id);
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    int area, oid, lat, snap_a, snap_i, t0, t1, got;
    bit stable;
    int cap_a[3];
    int cap_i[3];
    int exp_a[3];

    initial begin
        vecs[0]  = '{8'd10,  2'b00, 2'd0, 178,    179};
        vecs[1]  = '{8'd10,  2'b01, 2'd1, 100,    100};
        vecs[2]  = '{8'd10,  2'b10, 2'd2, 78,     79};
        vecs[3]  = '{8'd10,  2'b11, 2'd3, 178,    179};
        vecs[4]  = '{8'd255, 2'b00, 2'd1, 116079, 116080};
        vecs[5]  = '{8'd255, 2'b01, 2'd2, 65025,  65025};
        vecs[6]  = '{8'd255, 2'b10, 2'd3, 51054,  51055};
        vecs[7]  = '{8'd0,   2'b00, 2'd1, 0,      0};
        vecs[8]  = '{8'd1,   2'b10, 2'd2, 0,      1};
        vecs[9]  = '{8'd7,   2'b00, 2'd3, 87,     87};
        vecs[10] = '{8'd128, 2'b10, 2'd0, 12864,  12864};
        vecs[11] = '{8'd16,  2'b11, 2'd2, 457,    457};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_area", int'(out_area), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(negedge clk); rst = 1'b0; #1;
        check("rst_release_in_ready", int'(in_ready), 1);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].w, vecs[i].mode, vecs[i].id, 1'b1, area, oid, lat);
            check($sformatf("vec%0d_latency", i), lat, W + 1);
            check($sformatf("vec%0d_area", i), area, RND ? vecs[i].exp_rnd : vecs[i].exp_trunc);
            check($sformatf("vec%0d_id", i), oid, int'(vecs[i].id));
            check($sformatf("vec%0d_released", i), int'(out_valid), 0);
        end

        // Back-pressure: result held for 20 cycles
        do_req(8'd16, 2'b00, 2'd3, 1'b0, area, oid, lat);
        check("hold_area", area, 457);
        snap_a = area; snap_i = oid; stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (!out_valid || int'(out_area) != snap_a || int'(out_id) != snap_i || in_ready)
                stable = 1'b0;
        end
        check("hold_stable", int'(stable), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_valid", int'(out_valid), 0);
        check("hold_release_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        check("hold_single_transfer", int'(out_valid), 0);

        // Streamed requests with random consumer stalls
        exp_a[0] = 25; exp_a[1] = RND ? 64 : 63; exp_a[2] = 71406;
        got = 0;
        fork
            begin
                logic [W-1:0] ws[3];
                logic [1:0]   ms[3];
                ws[0] = 8'd5; ws[1] = 8'd9;  ws[2] = 8'd200;
                ms[0] = 2'b01; ms[1] = 2'b10; ms[2] = 2'b00;
                for (int i = 0; i < 3; i++) begin
                    int t;
                    @(negedge clk);
                    in_valid = 1'b1; in_width = ws[i]; in_mode = ms[i]; in_id = ID_W'(i + 1);
                    t = 0;
                    while (!in_ready && t < 200) begin @(negedge clk); t++; end
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                end
            end
            begin
                for (int c = 0; c < 400 && got < 3; c++) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        cap_a[got] = int'(out_area);
                        cap_i[got] = int'(out_id);
                        got++;
                    end
                end
            end
        join
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("stream_count", got, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stream%0d_area", i), (i < got) ? cap_a[i] : -1, exp_a[i]);
            check($sformatf("stream%0d_id", i), (i < got) ? cap_i[i] : -1, i + 1);
        end
        repeat (15) @(posedge clk);
        #1;
        check("stream_no_dup", int'(out_valid), 0);

        // Minimum request-to-request period with out_ready held high
        out_ready = 1'b1;
        t0 = -1; t1 = -1;
        for (int i = 0; i < 2; i++) begin
            int t;
            @(negedge clk);
            in_valid = 1'b1; in_width = (i == 0) ? 8'd2 : 8'd4; in_mode = 2'b01;
            in_id = (i == 0) ? 2'd1 : 2'd3;
            t = 0;
            while (!in_ready && t < 50) begin @(negedge clk); t++; end
            if (i == 0) t0 = cyc; else t1 = cyc;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        repeat (W + 2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("min_period", t1 - t0, W + 3);
        check("period_last_area", int'(out_area), 16);

        // Reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; in_width = 8'd10; in_mode = 2'b00; in_id = 2'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_area", int'(out_area), 0);
        check("midrst_out_id", int'(out_id), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        @(negedge clk); rst = 1'b0; #1;
        check("midrst_release_ready", int'(in_ready), 1);
        do_req(8'd3, 2'b01, 2'd2, 1'b1, area, oid, lat);
        check("after_rst_area", area, 9);
        check("after_rst_id", oid, 2);
        check("after_rst_latency", lat, W + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
